// File: rtl/qrd_row_feeder.sv
// qrd_row_feeder
//   Source-side scheduler for the QRD systolic core. Collects one augmented
//   4x5 complex matrix [H | y] (20 words, row-major, column 4 = y) over a
//   valid/ready stream, then plays it into the core's four skewed row inputs.
//   Row k is live for schedule counts S_k..S_k+4 and drives buffer[k][t-S_k];
//   rows 1..3 raise their diagonal flag at t = S_k + (k-1).
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   s_valid/s_ready     : upstream handshake; s_r/s_i carry the word
//   core_ready          : core accepts a new matrix (sampled only while waiting)
//   row_in_{1..4}_{r,i} : skewed row data, 0 outside each row's window
//   row_in_{1..3}_f     : diagonal-element flags
//   busy                : from first accepted word until last element driven
//   done                : one-cycle pulse after the final row-4 element
//
// Build option
//   FEEDER_PINGPONG_EN  : two buffers, next matrix loads while the current one
//                         is sent; back-to-back matrices run without a gap.

module qrd_row_feeder #(
  parameter int unsigned IN_W   = 14,
  parameter int unsigned START2 = 1,
  parameter int unsigned START3 = 21,
  parameter int unsigned START4 = 41,
  parameter int unsigned CNT_W  = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [IN_W-1:0] s_r,
  input  logic [IN_W-1:0] s_i,
  input  logic            core_ready,
  output logic [IN_W-1:0] row_in_1_r,
  output logic [IN_W-1:0] row_in_1_i,
  output logic [IN_W-1:0] row_in_2_r,
  output logic [IN_W-1:0] row_in_2_i,
  output logic [IN_W-1:0] row_in_3_r,
  output logic [IN_W-1:0] row_in_3_i,
  output logic [IN_W-1:0] row_in_4_r,
  output logic [IN_W-1:0] row_in_4_i,
  output logic            row_in_1_f,
  output logic            row_in_2_f,
  output logic            row_in_3_f,
  output logic            busy,
  output logic            done
);

  localparam int unsigned      NWORDS    = 20;
  localparam logic [4:0]       LAST_WORD = 5'(NWORDS - 1);
  localparam logic [CNT_W-1:0] T_LAST    = CNT_W'(START4 + 4);
  localparam logic [CNT_W-1:0] ROW_START [4] =
    '{CNT_W'(0), CNT_W'(START2), CNT_W'(START3), CNT_W'(START4)};

  typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_SEND} state_t;

  state_t           state_q, state_d;
  logic [4:0]       widx_q, widx_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [IN_W-1:0]  row_r_q [4];
  logic [IN_W-1:0]  row_r_d [4];
  logic [IN_W-1:0]  row_i_q [4];
  logic [IN_W-1:0]  row_i_d [4];
  logic [2:0]       flag_q, flag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_word;
  logic [IN_W-1:0]  cur_r [NWORDS];
  logic [IN_W-1:0]  cur_i [NWORDS];
  logic [CNT_W-1:0] offs;
  logic [4:0]       addr;

  assign accept    = s_valid && s_ready;
  assign last_word = (widx_q == LAST_WORD);

`ifdef FEEDER_PINGPONG_EN
  logic [IN_W-1:0] buf_r_q [2][NWORDS];
  logic [IN_W-1:0] buf_i_q [2][NWORDS];
  logic [1:0]      full_q, full_d;
  logic            wsel_q, wsel_d;
  logic            rsel_q, rsel_d;

  // Loading is independent of sending: accept whenever the write buffer is free.
  assign s_ready = ~full_q[wsel_q];

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_r_q[wsel_q][widx_q] <= s_r;
      buf_i_q[wsel_q][widx_q] <= s_i;
    end
  end

  // Read through the buffer selected for the coming cycle so a swap at the
  // end of a matrix feeds the new matrix's first element without a bubble.
  always_comb begin
    for (int unsigned w = 0; w < NWORDS; w++) begin
      cur_r[w] = buf_r_q[rsel_d][w];
      cur_i[w] = buf_i_q[rsel_d][w];
    end
  end
`else
  logic [IN_W-1:0] buf_r_q [NWORDS];
  logic [IN_W-1:0] buf_i_q [NWORDS];

  assign s_ready = (state_q == ST_LOAD);

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_r_q[widx_q] <= s_r;
      buf_i_q[widx_q] <= s_i;
    end
  end

  always_comb begin
    for (int unsigned w = 0; w < NWORDS; w++) begin
      cur_r[w] = buf_r_q[w];
      cur_i[w] = buf_i_q[w];
    end
  end
`endif

  // Control: word index, state and schedule counter.
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    t_d     = t_q;
    done_d  = 1'b0;
`ifdef FEEDER_PINGPONG_EN
    full_d  = full_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
`endif

    if (accept) begin
      if (last_word) begin
        widx_d = '0;
`ifdef FEEDER_PINGPONG_EN
        full_d[wsel_q] = 1'b1;
        wsel_d         = ~wsel_q;
`endif
      end else begin
        widx_d = widx_q + 5'd1;
      end
    end

    case (state_q)
      ST_LOAD: begin
`ifdef FEEDER_PINGPONG_EN
        if (full_d[rsel_q]) state_d = ST_WAIT;
`else
        if (accept && last_word) state_d = ST_WAIT;
`endif
      end
      ST_WAIT: begin
        if (core_ready) begin
          state_d = ST_SEND;
          t_d     = '0;
        end
      end
      ST_SEND: begin
        if (t_q == T_LAST) begin
          done_d = 1'b1;
          t_d    = '0;
`ifdef FEEDER_PINGPONG_EN
          full_d[rsel_q] = 1'b0;
          rsel_d         = ~rsel_q;
          if (full_q[~rsel_q]) state_d = core_ready ? ST_SEND : ST_WAIT;
          else                 state_d = ST_LOAD;
`else
          state_d = ST_LOAD;
`endif
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Row outputs are computed from the next state/count and registered, so the
  // value for count t is on the pins exactly while the counter holds t.
  always_comb begin
    offs   = '0;
    addr   = '0;
    flag_d = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      row_r_d[k] = '0;
      row_i_d[k] = '0;
    end
    if (state_d == ST_SEND) begin
      for (int unsigned k = 0; k < 4; k++) begin
        offs = t_d - ROW_START[k];
        if ((t_d >= ROW_START[k]) && (offs <= CNT_W'(4))) begin
          addr       = 5'(k * 5) + offs[4:0];
          row_r_d[k] = cur_r[addr];
          row_i_d[k] = cur_i[addr];
        end
      end
      for (int unsigned k = 0; k < 3; k++) begin
        flag_d[k] = (t_d == (ROW_START[k] + CNT_W'(k)));
      end
    end
    busy_d = (state_d != ST_LOAD) || (widx_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD;
      widx_q  <= '0;
      t_q     <= '0;
      for (int unsigned k = 0; k < 4; k++) begin
        row_r_q[k] <= '0;
        row_i_q[k] <= '0;
      end
      flag_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef FEEDER_PINGPONG_EN
      full_q  <= '0;
      wsel_q  <= 1'b0;
      rsel_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      t_q     <= t_d;
      for (int unsigned k = 0; k < 4; k++) begin
        row_r_q[k] <= row_r_d[k];
        row_i_q[k] <= row_i_d[k];
      end
      flag_q  <= flag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef FEEDER_PINGPONG_EN
      full_q  <= full_d;
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
`endif
    end
  end

  assign row_in_1_r = row_r_q[0];
  assign row_in_1_i = row_i_q[0];
  assign row_in_2_r = row_r_q[1];
  assign row_in_2_i = row_i_q[1];
  assign row_in_3_r = row_r_q[2];
  assign row_in_3_i = row_i_q[2];
  assign row_in_4_r = row_r_q[3];
  assign row_in_4_i = row_i_q[3];
  assign row_in_1_f = flag_q[0];
  assign row_in_2_f = flag_q[1];
  assign row_in_3_f = flag_q[2];
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/qrd_row_feeder.md
Name: qrd_row_feeder

Overview:
- Source-side scheduler for the QRD systolic core. It accepts one augmented 4x5 complex matrix [H | y] as a serial word stream over a valid/ready handshake and buffers it.
- It then drives the core's four skewed row inputs (row_in_k_r/i) and the diagonal flags (row_in_1..3_f) on the fixed per-row schedule the core expects.
- It sits between the upstream matrix source and the QRD core row input ports.

Parameters:
- IN_W, 14, width of each real/imag sample (two's complement; y carries 10 fractional bits).
- START2, 1, cycle offset of row 2's first element relative to row 1's first element.
- START3, 21, cycle offset of row 3's first element.
- START4, 41, cycle offset of row 4's first element.
- CNT_W, 7, schedule counter width; must hold START4+5.

Ports:
- clk, input, 1, single clock; all state is on the rising edge.
- rst, input, 1, reset; asynchronous and active-high.
- s_valid, input, 1, upstream word valid.
- s_ready, output, 1, feeder can accept a word.
- s_r, input, IN_W, real part of the word.
- s_i, input, IN_W, imaginary part of the word.
- core_ready, input, 1, in_ready of the QRD core.
- row_in_1_r, row_in_1_i, row_in_2_r, row_in_2_i, row_in_3_r, row_in_3_i, row_in_4_r, row_in_4_i: output, IN_W each, skewed row data to the core.
- row_in_1_f, row_in_2_f, row_in_3_f: output, 1 each, diagonal-element flags.
- busy, output, 1, high from the first accepted word until the last scheduled element has been driven.
- done, output, 1, one-cycle pulse in the cycle after the final row-4 element.

Behaviour:
- Reset (async, rst=1): state=LOAD, word index=0, schedule counter=0. All row_in_* = 0, all flags = 0, s_ready=1, busy=0, done=0. Asserting rst mid-transfer or mid-send aborts immediately with no partial output afterwards.
- Word order: row-major, 20 words. Index w maps to row w/5 and column w%5. Column 4 is y.
- A transfer happens when s_valid && s_ready. Words are stored in a 4x5 register buffer.
- States:
  - LOAD: s_ready=1. The 20th accepted word moves to WAIT on the next edge. A word presented in WAIT or SEND is not accepted (s_ready=0).
  - WAIT: s_ready=0. Enter SEND on the first edge with core_ready=1. The schedule counter t=0 in the first SEND cycle.
  - SEND: t increments every cycle; core_ready is ignored once SEND starts.
    - Row k is active for t in [S_k, S_k+4], with S_1=0, S_2=START2, S_3=START3, S_4=START4.
    - While active, row k drives buffer[k][t-S_k]. Outside its window it drives 0.
    - row_in_k_f=1 exactly when t = S_k + (k-1), for k=1..3 (the diagonal element).
    - Outputs are registered: values for counter value t appear in the cycle the counter holds t, with no extra pipeline stage.
  - When t = START4+4: the next edge returns to LOAD, all outputs go to 0, done=1 for one cycle, and the word index resets.
- Overlapping windows (e.g. rows 1 and 2 at t=1..4) drive concurrently and independently.
- No arithmetic: data passes through bit-exact, sign preserved.
- Only the parameter constraints given here are supported: START2 >= 1, START3 > START2, START4 > START3. Violating them is illegal.

Optional Feature:
- FEEDER_PINGPONG_EN defined:
  - Two 4x5 buffers. s_ready stays 1 during WAIT and SEND while the alternate buffer is not full, so the next matrix loads while the current one is sent.
  - On SEND completion, if the alternate buffer holds 20 words, go straight to WAIT (or to SEND on the same edge if core_ready=1) and swap buffers.
  - busy stays high across back-to-back matrices. done pulses once per matrix.
- Undefined: single buffer, behaviour exactly as above.

Test Plan:
- Basic schedule: load H[j][k]=10*j+k+1 (imag = negated real), y_r={181,362,543,724}, y_i={724,362,543,181}, core_ready=1.
  - Row 1 shows 1,2,3,4,181 at t=0..4, with row_in_1_f only at t=0.
  - Row 2 shows 11..14,362 at t=1..5, with flag at t=2.
  - Row 3 at t=21..25, flag at t=23.
  - Row 4 at t=41..45.
  - done at t=46. All idle outputs are 0.
- Backpressure: hold core_ready=0 for 7 cycles after the 20th word -> no nonzero output and no flag until core_ready rises; the schedule is then identical to the basic test, shifted.
- Upstream gaps: toggle s_valid randomly during load; present a 21st word during SEND -> s_ready=0, the word is not stored, and the output is bit-exact to the basic test.
- Async reset at t=23 -> all outputs 0 in the same cycle and s_ready=1. A fresh load then produces the full basic schedule.
- Sign extremes: elements -8192 and 8191 in every position -> output bit-exact, no sign corruption.
- FEEDER_PINGPONG_EN: stream two matrices back-to-back -> the second starts at the cycle after the first one's done, with no idle gap, and done pulses twice.
